spart_tx_fifo: RTL and testbench
================================

// Module: spart_tx_fifo
// PURPOSE
//   Parametrised SPART serial transmitter, successor to the single-byte tx path.
//   Adds a write FIFO so software can queue several characters without waiting on tbr.
//   Adds runtime-selectable stop-bit count and an optional parity bit.
//   Sits between the SPART bus interface (writes, divisor register) and the txd pin.
// PARAMETERS
//   DATA_W      8   data bits per frame, 5..9, sent LSB first
//   FIFO_DEPTH  4   transmit FIFO entries, power of 2, >=2
//   DIV_W       16  width of the baud divisor
// PORTS
//   clk          in   1                  system clock, sole clock domain
//   rst          in   1                  one clock; reset is synchronous and active-high
//   wr_en        in   1                  push wr_data into FIFO this cycle
//   wr_data      in   DATA_W             character to queue
//   divisor      in   DIV_W              bit period = divisor+1 clk cycles
//   two_stop     in   1                  0: one stop bit, 1: two stop bits
//   parity_odd   in   1                  parity sense, only with SPART_TX_PARITY_EN
//   tbr          out  1                  FIFO not full; write accepted
//   busy         out  1                  frame in progress or FIFO non-empty
//   fifo_count   out  $clog2(DEPTH)+1    current FIFO occupancy
//   overflow     out  1                  1-cycle pulse: wr_en while full, data dropped
//   txd          out  1                  serial line, idle high, registered
// BEHAVIOUR
//   Reset (rst=1 at posedge): txd=1, tbr=1, busy=0, fifo_count=0, overflow=0, FSM=IDLE.
//   Reset mid-frame aborts the frame immediately; txd goes 1 the next cycle; FIFO is flushed.
//   FIFO: circular buffer with wr/rd pointers plus count.
//     Push when wr_en && !full; count++.
//     Push with a simultaneous pop: count is unchanged.
//     wr_en while full: data dropped, overflow=1 for one cycle.
//     Pop happens only on the IDLE->START transition.
//     Pointers wrap modulo FIFO_DEPTH.
//   tbr = (fifo_count != FIFO_DEPTH); combinational from the count register.
//   FSM states: IDLE, START, DATA, PARITY, STOP.
//     IDLE -> START when FIFO is non-empty.
//       Pop the head into the shift register.
//       Latch divisor and two_stop for the whole frame; later changes affect only the next frame.
//     START: txd=0 for one bit period, then -> DATA.
//     DATA: shift LSB first for DATA_W bit periods.
//       Then -> PARITY if SPART_TX_PARITY_EN, else -> STOP.
//     PARITY: one bit period, then -> STOP.
//     STOP: txd=1 for 1 or 2 bit periods.
//       Then -> START directly if FIFO non-empty (back-to-back frames, no idle gap).
//       Otherwise -> IDLE.
//   Baud counter:
//     Loads the latched divisor at each bit start and decrements every cycle.
//     Bit ends on the cycle the counter reads 0.
//     divisor=0 gives 1-cycle bits; this must work.
//   Bit counter: counts DATA_W down to 0 in DATA; counts stop bits in STOP.
//   Latency: wr_en at cycle N into empty FIFO with FSM in IDLE.
//     Entry visible at N+1; FSM enters START at N+2; txd=0 from cycle N+2.
//   txd is driven from a register; no combinational path from inputs to txd.
//   busy = (state != IDLE) || (fifo_count != 0).
// CONFIGURATION
//   SPART_TX_PARITY_EN defined:
//     One parity bit is sent after the data bits.
//     Value = ^data for even parity (parity_odd=0), ~^data for odd parity (parity_odd=1).
//     parity_odd is latched at frame start.
//   SPART_TX_PARITY_EN undefined:
//     No PARITY state; parity_odd is unused; frame = start + DATA_W + stop bits.
// TESTING
//   1. Reset check.
//      Stimulus: assert rst 3 cycles.
//      Response: txd=1, tbr=1, busy=0, fifo_count=0.
//   2. Single frame.
//      Stimulus: divisor=3, write 8'hA5.
//      Response: txd=0 from N+2; then bits 1,0,1,0,0,1,0,1; then 1.
//      Each bit lasts 4 clks; frame = 40 clks without parity.
//   3. Back-to-back.
//      Stimulus: divisor=0, write 8'h55 then 8'h0F.
//      Response: second start bit immediately follows the first stop bit, no idle cycle.
//      busy drops 1 cycle after the final stop bit.
//   4. Full/overflow.
//      Stimulus: DEPTH=4, divisor=15, write 6 bytes on consecutive cycles.
//      Response: first byte popped; 4 stored; tbr=0.
//      6th write gives overflow=1 and is dropped; 5 frames in total.
//   5. Two stop bits plus divisor change.
//      Stimulus: two_stop=1, write 2 bytes, change divisor mid-frame 1.
//      Response: two 1-bits between frames; frame 2 uses the new divisor.
//   6. Parity, only with SPART_TX_PARITY_EN.
//      Stimulus: 8'h07 with parity_odd=0.
//      Response: parity bit=1. With parity_odd=1, parity bit=0.
//   7. Reset mid-frame.
//      Stimulus: assert rst during DATA with 2 bytes queued.
//      Response: txd=1 next cycle; fifo_count=0; no further frames.

Source files
------------

// File: rtl/spart_tx_fifo.sv
// SPART serial transmitter with a write FIFO, runtime 1/2 stop bits and a registered txd.
// Define SPART_TX_PARITY_EN to append a parity bit (even/odd chosen by parity_odd).
module spart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [DIV_W-1:0]            divisor,
  input  logic                        two_stop,
  input  logic                        parity_odd,
  output logic                        tbr,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        txd
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [DIV_W-1:0] BAUD_ONE = DIV_W'(1);

`ifdef SPART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              overflow_reg;
  logic              full, empty, push, pop;

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  baud_reg, baud_next;
  logic [DIV_W-1:0]  div_reg, div_next;
  logic [BIT_W-1:0]  bit_reg, bit_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic              two_stop_reg, two_stop_next;
  logic              txd_reg, txd_next;
  logic              bit_end;
`ifdef SPART_TX_PARITY_EN
  logic              parity_reg, parity_next;
`else
  logic              unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign push    = wr_en && !full;
  assign bit_end = (baud_reg == '0);

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
      overflow_reg <= wr_en && full;
    end
  end

  always_comb begin
    state_next    = state_reg;
    baud_next     = baud_reg;
    div_next      = div_reg;
    bit_next      = bit_reg;
    shift_next    = shift_reg;
    two_stop_next = two_stop_reg;
    txd_next      = txd_reg;
    pop           = 1'b0;
`ifdef SPART_TX_PARITY_EN
    parity_next   = parity_reg;
`endif
    if (state_reg != IDLE) baud_next = baud_reg - BAUD_ONE;
    case (state_reg)
      IDLE: pop = !empty;
      START: if (bit_end) begin
        state_next = DATA;
        baud_next  = div_reg;
        bit_next   = BIT_W'(DATA_W - 1);
        txd_next   = shift_reg[0];
      end
      DATA: if (bit_end) begin
        baud_next = div_reg;
        if (bit_reg == '0) begin
`ifdef SPART_TX_PARITY_EN
          state_next = PARITY;
          txd_next   = parity_reg;
`else
          state_next = STOP;
          txd_next   = 1'b1;
          bit_next   = two_stop_reg ? BIT_ONE : '0;
`endif
        end else begin
          shift_next = shift_reg >> 1;
          txd_next   = shift_reg[1];
          bit_next   = bit_reg - BIT_ONE;
        end
      end
`ifdef SPART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_next = STOP;
        baud_next  = div_reg;
        txd_next   = 1'b1;
        bit_next   = two_stop_reg ? BIT_ONE : '0;
      end
`endif
      // bit_reg holds the stop bits still to send after the current one.
      STOP: if (bit_end) begin
        if (bit_reg != '0) begin
          bit_next  = bit_reg - BIT_ONE;
          baud_next = div_reg;
        end else if (!empty) begin
          pop = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Frame start: pop the head and freeze the line settings for the whole frame.
    if (pop) begin
      state_next    = START;
      shift_next    = mem[rd_ptr_reg];
      div_next      = divisor;
      baud_next     = divisor;
      two_stop_next = two_stop;
      txd_next      = 1'b0;
`ifdef SPART_TX_PARITY_EN
      parity_next   = (^mem[rd_ptr_reg]) ^ parity_odd;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_reg     <= '0;
      div_reg      <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      two_stop_reg <= 1'b0;
      txd_reg      <= 1'b1;
`ifdef SPART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      baud_reg     <= baud_next;
      div_reg      <= div_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      two_stop_reg <= two_stop_next;
      txd_reg      <= txd_next;
`ifdef SPART_TX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  assign tbr        = !full;
  assign busy       = (state_reg != IDLE) || !empty;
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;
  assign txd        = txd_reg;

endmodule

// File: tb/tb_spart_tx_fifo.sv
// Scoreboard bench for spart_tx_fifo: a timing model predicts each frame's start edge,
// a monitor decodes txd frames and status outputs and compares them against the model.
module tb_spart_tx_fifo;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;
`ifdef SPART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic [DIV_W-1:0] divisor = '0;
  logic             two_stop = 1'b0;
  logic             parity_odd = 1'b0;
  logic             tbr, busy, overflow, txd;
  logic [2:0]       fifo_count;

  spart_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .divisor(divisor),
    .two_stop(two_stop), .parity_odd(parity_odd), .tbr(tbr), .busy(busy),
    .fifo_count(fifo_count), .overflow(overflow), .txd(txd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         accept;
    int         start;
    int         fin;
    logic [7:0] data;
    int         dv;
    bit         ts;
    bit         po;
  } frame_t;

  frame_t model_q[$];
  frame_t exp_q[$];
  bit     rej[int];
  int     edge_cnt = 0;
  int     checks = 0;
  int     errors = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edge_cnt);
    end
  endfunction

  function automatic int frame_len(input int dv, input bit ts);
    return (dv + 1) * (1 + DATA_W + PAR_BITS + (ts ? 2 : 1));
  endfunction

  // Called right after a negedge; the write is sampled at the next posedge (edge k).
  task automatic do_write(input logic [7:0] d, input int dv, input bit ts, input bit po);
    int     k, occ, prev_end;
    frame_t f;
    k   = edge_cnt + 1;
    occ = 0;
    foreach (model_q[i]) if (model_q[i].accept < k && model_q[i].start >= k) occ++;
    wr_en   = 1'b1;
    wr_data = d;
    if (occ == FIFO_DEPTH) begin
      rej[k] = 1'b1;
      $display("write %02h dropped at edge %0d", d, k);
    end else begin
      prev_end = (model_q.size() > 0) ? model_q[model_q.size()-1].fin : 0;
      f.accept = k;
      f.start  = (k + 1 > prev_end) ? k + 1 : prev_end;
      f.fin    = f.start + frame_len(dv, ts);
      f.data   = d;
      f.dv     = dv;
      f.ts     = ts;
      f.po     = po;
      model_q.push_back(f);
      exp_q.push_back(f);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int target, guard;
    target = (model_q.size() > 0) ? model_q[model_q.size()-1].fin + 2 : edge_cnt;
    guard  = 0;
    while (edge_cnt < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) check("wait_idle timeout", edge_cnt, target);
  endtask

  task automatic wait_edge(input int target);
    while (edge_cnt < target) @(negedge clk);
  endtask

  // Monitor: decodes txd frames and checks the status outputs every cycle.
  logic [15:0] fbits;
  int          nb, per, mon_i, idx, ones, exp_cnt, bexp;
  bit          mon_active = 1'b0;
  bit          bit_bad = 1'b0;
  bit          spur_seen = 1'b0;
  bit          exp_busy;
  frame_t      cur;

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (txd == 1'b0) begin
          if (exp_q.size() == 0) begin
            if (!spur_seen) check("idle txd", txd, 1);
            spur_seen = 1'b1;
          end else begin
            cur = exp_q.pop_front();
            check("start edge", edge_cnt, cur.start);
            fbits = '0;
            for (int i = 0; i < DATA_W; i++) fbits[1+i] = cur.data[i];
            idx = 1 + DATA_W;
`ifdef SPART_TX_PARITY_EN
            ones = $countones(cur.data);
            fbits[idx] = cur.po ? (ones % 2 == 0) : (ones % 2 == 1);
            idx++;
`endif
            fbits[idx] = 1'b1;
            idx++;
            if (cur.ts) begin
              fbits[idx] = 1'b1;
              idx++;
            end
            nb         = idx;
            per        = cur.dv + 1;
            mon_i      = 0;
            bit_bad    = 1'b0;
            mon_active = 1'b1;
          end
        end else begin
          spur_seen = 1'b0;
          if (exp_q.size() > 0 && edge_cnt > exp_q[0].start) begin
            cur = exp_q.pop_front();
            check("start missing", edge_cnt, cur.start);
          end
        end
      end
      if (mon_active) begin
        bexp = int'(fbits[mon_i / per]);
        if (txd !== fbits[mon_i / per]) bit_bad = 1'b1;
        if (mon_i % per == per - 1) begin
          check($sformatf("frame %02h bit %0d", cur.data, mon_i / per), bit_bad ? 1 - bexp : bexp, bexp);
          bit_bad = 1'b0;
        end
        mon_i++;
        if (mon_i == nb * per) begin
          mon_active = 1'b0;
          $display("frame data=%02h div=%0d stops=%0d po=%0d start_edge=%0d", cur.data, cur.dv,
                   cur.ts ? 2 : 1, cur.po, cur.start);
        end
      end
      if (edge_cnt >= 1) begin
        exp_cnt  = 0;
        exp_busy = 1'b0;
        foreach (model_q[i]) begin
          if (model_q[i].accept <= edge_cnt && model_q[i].start > edge_cnt) exp_cnt++;
          if (model_q[i].accept <= edge_cnt && model_q[i].fin > edge_cnt) exp_busy = 1'b1;
        end
        check("fifo_count", fifo_count, exp_cnt);
        check("tbr", tbr, (exp_cnt != FIFO_DEPTH) ? 1 : 0);
        check("busy", busy, exp_busy);
        check("overflow", overflow, rej.exists(edge_cnt));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
    $fatal(1, "watchdog");
  end

  int s1, dv_r, n_r;
  bit ts_r, po_r;

  initial begin : stim
    // Reset held over three edges.
    repeat (3) @(negedge clk);
    check("reset txd", txd, 1);
    check("reset tbr", tbr, 1);
    check("reset busy", busy, 0);
    check("reset fifo_count", fifo_count, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame, 4-clock bits.
    divisor = 16'd3;
    do_write(8'hA5, 3, 1'b0, 1'b0);
    wait_idle();

    // Back-to-back frames at 1-clock bits.
    divisor = 16'd0;
    do_write(8'h55, 0, 1'b0, 1'b0);
    do_write(8'h0F, 0, 1'b0, 1'b0);
    wait_idle();

    // Fill past capacity: sixth write is dropped.
    divisor = 16'd15;
    for (int i = 0; i < 6; i++) do_write(8'(8'h30 + i), 15, 1'b0, 1'b0);
    wait_idle();

    // Two stop bits; divisor changes during frame 1 and applies to frame 2 only.
    divisor  = 16'd2;
    two_stop = 1'b1;
    do_write(8'hC3, 2, 1'b1, 1'b0);
    do_write(8'h3C, 5, 1'b1, 1'b0);
    s1 = model_q[model_q.size()-2].start;
    wait_edge(s1 + 5);
    divisor = 16'd5;
    wait_idle();
    two_stop = 1'b0;

    // Parity sense: first frame even, second odd.
    divisor    = 16'd1;
    parity_odd = 1'b0;
    do_write(8'h07, 1, 1'b0, 1'b0);
    do_write(8'h07, 1, 1'b0, 1'b1);
    parity_odd = 1'b1;
    wait_idle();
    parity_odd = 1'b0;

    // Randomised batches; settings only change while the line is idle.
    for (int b = 0; b < 6; b++) begin
      dv_r = $urandom_range(0, 3);
      ts_r = 1'($urandom_range(0, 1));
      po_r = 1'($urandom_range(0, 1));
      n_r  = $urandom_range(3, 8);
      divisor    = DIV_W'(dv_r);
      two_stop   = ts_r;
      parity_odd = po_r;
      for (int j = 0; j < n_r; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_write(8'($urandom), dv_r, ts_r, po_r);
      end
      wait_idle();
    end

    // Reset during DATA with two characters still queued.
    divisor    = 16'd3;
    two_stop   = 1'b0;
    parity_odd = 1'b0;
    do_write(8'h81, 3, 1'b0, 1'b0);
    do_write(8'h42, 3, 1'b0, 1'b0);
    do_write(8'h24, 3, 1'b0, 1'b0);
    s1 = model_q[model_q.size()-3].start;
    wait_edge(s1 + 12);
    rst = 1'b1;
    model_q.delete();
    exp_q.delete();
    rej.delete();
    @(posedge clk);
    #1;
    check("mid-frame reset txd", txd, 1);
    check("mid-frame reset fifo_count", fifo_count, 0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);

    check("frames outstanding", exp_q.size(), 0);
    check("frame in progress", mon_active, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
